// File: rtl/rmw_pkg.sv
// rtl/rmw_pkg.sv - shared word-store client definitions
//
// Purpose: widths, default read latency and FSM state encoding shared by the
// distributor clients of the 1024x12 word store.
// Ports: none (package).
package rmw_pkg;

  localparam int WORD_W     = 12;
  localparam int ADDR_W     = 10;
  localparam int RD_LAT_DEF = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WRITE   = 2'd2,
    HOLD    = 2'd3
  } rmw_state_t;

endpackage

// File: rtl/rmw_word_writer.sv
// rtl/rmw_word_writer.sv - masked read-modify-write client for the word store
//
// Purpose: accepts one masked word update per request, reads the stored word
// through the distributor old-word path, merges the masked bits and writes
// the result back, holding busy (the distributor grant) for the whole
// transaction.
// Optional feature macro: FULL_MASK_BYPASS_EN -- a request with an all-ones
// mask skips the read and writes req_data directly.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   req, req_addr, req_data, req_mask  update request (level, sampled in IDLE)
//   ack, done                        one-cycle accept / completion pulses
//   busy                             distributor grant line
//   wrdOut, wrdAddr, wren            write path to the store
//   oldWrd, oldWrdAddr, oldRdEn      read path from the store
module rmw_word_writer
  import rmw_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_data,
  input  logic [WORD_W-1:0] req_mask,
  output logic              ack,
  output logic              done,
  output logic              busy,
  output logic [WORD_W-1:0] wrdOut,
  output logic [ADDR_W-1:0] wrdAddr,
  output logic              wren,
  input  logic [WORD_W-1:0] oldWrd,
  output logic [ADDR_W-1:0] oldWrdAddr,
  output logic              oldRdEn
);

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  rmw_state_t        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [WORD_W-1:0] mask_q, mask_d;
  logic              ack_q, ack_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              wren_q, wren_d;
  logic              rd_en_q, rd_en_d;
  logic [WORD_W-1:0] wrd_out_q, wrd_out_d;
  logic [ADDR_W-1:0] wrd_addr_q, wrd_addr_d;
  logic [ADDR_W-1:0] old_addr_q, old_addr_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    wren_d     = 1'b0;
    rd_en_d    = 1'b0;
    wrd_out_d  = wrd_out_q;
    wrd_addr_d = wrd_addr_q;
    old_addr_d = old_addr_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d = req_addr;
          data_d = req_data;
          mask_d = req_mask;
          ack_d  = 1'b1;
          busy_d = 1'b1;
`ifdef FULL_MASK_BYPASS_EN
          if (&req_mask) begin
            // Every bit is replaced, so the stored word is irrelevant.
            wren_d     = 1'b1;
            wrd_out_d  = req_data;
            wrd_addr_d = req_addr;
            state_d    = WRITE;
          end else begin
            rd_en_d    = 1'b1;
            old_addr_d = req_addr;
            cnt_d      = LAT_LOAD;
            state_d    = RD_WAIT;
          end
`else
          rd_en_d    = 1'b1;
          old_addr_d = req_addr;
          cnt_d      = LAT_LOAD;
          state_d    = RD_WAIT;
`endif
        end
      end
      RD_WAIT: begin
        // Counter reaches 0 exactly on the edge where oldWrd is valid.
        if (cnt_q == 3'd0) begin
          wrd_out_d  = (oldWrd & ~mask_q) | (data_q & mask_q);
          wrd_addr_d = addr_q;
          wren_d     = 1'b1;
          state_d    = WRITE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      WRITE: begin
        // Keep the grant one more cycle so the distributor registers the write.
        state_d = HOLD;
      end
      HOLD: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      wren_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      wrd_out_q  <= '0;
      wrd_addr_q <= '0;
      old_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      wren_q     <= wren_d;
      rd_en_q    <= rd_en_d;
      wrd_out_q  <= wrd_out_d;
      wrd_addr_q <= wrd_addr_d;
      old_addr_q <= old_addr_d;
    end
  end

  assign ack        = ack_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign wren       = wren_q;
  assign oldRdEn    = rd_en_q;
  assign wrdOut     = wrd_out_q;
  assign wrdAddr    = wrd_addr_q;
  assign oldWrdAddr = old_addr_q;

endmodule
